// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and digit bundle between a binary source and bin_to_bcd_seq.
// master drives start/bin; slave returns busy, done, overflow and four BCD digits.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH = 14
);
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       d_ones;
    logic [3:0]       d_tens;
    logic [3:0]       d_hund;
    logic [3:0]       d_thou;

    modport master (
        output start, bin,
        input  busy, done, overflow,
        input  d_ones, d_tens, d_hund, d_thou
    );

    modport slave (
        input  start, bin,
        output busy, done, overflow,
        output d_ones, d_tens, d_hund, d_thou
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, reset (async, active-low), bus (slave: start/bin in; busy/done/overflow/digits out).
module bin_to_bcd_seq #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic            clk,
    input  logic            reset,
    bin_to_bcd_seq_if.slave bus
);
    localparam int SW = 16 + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf_pending;
    logic            ovf_in;
    logic            last;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign ovf_in = ({{(32-WIDTH){1'b0}}, bus.bin} > 32'(MAX_VAL));

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 on each BCD nibble >=5 so the following shift carries
    // correctly into the next decimal digit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = scratch[WIDTH+4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scratch      <= '0;
            cnt          <= '0;
            ovf_pending  <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.d_ones   <= 4'd0;
            bus.d_tens   <= 4'd0;
            bus.d_hund   <= 4'd0;
            bus.d_thou   <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        scratch     <= {16'd0, bus.bin};
                        cnt         <= '0;
                        ovf_pending <= ovf_in;
                    end
                end
                SHIFT: begin
                    scratch <= adj << 1;
                    cnt     <= cnt + CW'(1);
                end
                FINISH: begin
                    bus.done <= 1'b1;
                    if (ovf_pending) begin
                        bus.overflow <= 1'b1;
                        bus.d_ones   <= 4'd9;
                        bus.d_tens   <= 4'd9;
                        bus.d_hund   <= 4'd9;
                        bus.d_thou   <= 4'd9;
                    end else begin
                        bus.overflow <= 1'b0;
                        bus.d_ones   <= scratch[WIDTH    +: 4];
                        bus.d_tens   <= scratch[WIDTH+4  +: 4];
                        bus.d_hund   <= scratch[WIDTH+8  +: 4];
                        bus.d_thou   <= scratch[WIDTH+12 +: 4];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
